// File: rtl/fsub_result_buffer.sv
// ============================================================================
//  Module      : fsub_result_buffer
//  Description : Registered output stage for the single-precision subtractor.
//                Captures {result, overflow} under a valid/ready handshake
//                into a small in-order FIFO, presents the head entry to the
//                register-file writeback, keeps sticky exception flags
//                (overflow, NaN, zero) and counts retired results.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsub_result_buffer #(
    parameter int DEPTH = 2,   // number of FIFO entries, power of two, >= 2
    parameter int CNT_W = 16   // width of the retired-result counter
) (
    input  logic             clk,
    input  logic             rst,

    // Producer side (subtractor)
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_y,
    input  logic             in_ovf,

    // Consumer side (writeback)
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic             out_ovf,

    // Status
    input  logic             flag_clr,
    output logic             flag_ovf,
    output logic             flag_nan,
    output logic             flag_zero,
    output logic [CNT_W-1:0] retired
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int PTR_W = $clog2(DEPTH);

    // Occupancy needs one more bit than the pointers so "full" is expressible.
    localparam logic [PTR_W:0]   c_full    = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   c_cnt_one = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_ret_one = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0]      r_mem_y   [DEPTH];
    logic             r_mem_ovf [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             r_flag_ovf;
    logic             r_flag_nan;
    logic             r_flag_zero;
    logic [CNT_W-1:0] r_retired;

    // ------------------------------------------------------------------------
    // Combinational handshake and classification
    // ------------------------------------------------------------------------
    logic w_in_ready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;
    logic w_is_nan;
    logic w_is_zero;

    // Handshake decode; in_ready looks only at registered occupancy so there
    // is no combinational path from out_ready back to the producer.
    always_comb begin
        w_in_ready  = (r_count != c_full);
        w_out_valid = (r_count != '0);
        w_push      = in_valid & w_in_ready;
        w_pop       = w_out_valid & out_ready;
    end

    // Classify the incoming result; infinity (mant==0) is not a NaN, and a
    // zero of either sign counts as zero.
    always_comb begin
        w_is_nan  = (in_y[30:23] == 8'hFF) && (in_y[22:0] != 23'd0);
        w_is_zero = (in_y[30:0] == 31'd0);
    end

    // ------------------------------------------------------------------------
    // Entry storage: written on push, deliberately not reset
    // ------------------------------------------------------------------------
    // Capture the pushed word at the write pointer.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_y[r_wptr]   <= in_y;
            r_mem_ovf[r_wptr] <= in_ovf;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers and occupancy
    // ------------------------------------------------------------------------
    // Advance pointers on push/pop; DEPTH is a power of two so they wrap
    // naturally. Reset overrides any simultaneous handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Retired-result counter
    // ------------------------------------------------------------------------
    // Count every pop, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_pop) begin
            r_retired <= r_retired + c_ret_one;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky exception flags
    // ------------------------------------------------------------------------
    // Flags are evaluated on data at push time. A clear and a setting push in
    // the same cycle leave that flag set while the others clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag_ovf  <= 1'b0;
            r_flag_nan  <= 1'b0;
            r_flag_zero <= 1'b0;
        end else begin
            r_flag_ovf  <= (r_flag_ovf  & ~flag_clr) | (w_push & in_ovf);
            r_flag_nan  <= (r_flag_nan  & ~flag_clr) | (w_push & w_is_nan);
            r_flag_zero <= (r_flag_zero & ~flag_clr) | (w_push & w_is_zero);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // Head entry is gated to zero while the buffer is empty so stale storage
    // never reaches the writeback port.
    always_comb begin
        in_ready  = w_in_ready;
        out_valid = w_out_valid;
        out_y     = w_out_valid ? r_mem_y[r_rptr]   : 32'd0;
        out_ovf   = w_out_valid ? r_mem_ovf[r_rptr] : 1'b0;
        flag_ovf  = r_flag_ovf;
        flag_nan  = r_flag_nan;
        flag_zero = r_flag_zero;
        retired   = r_retired;
    end

endmodule

`default_nettype wire

// File: tb/tb_fsub_result_buffer.sv
// ============================================================================
//  Module      : tb_fsub_result_buffer
//  Description : Self-checking bench for fsub_result_buffer. A queue-based
//                reference model tracks the expected FIFO contents, sticky
//                flags and retired count; directed scenarios pin literal
//                values, then a randomized phase exercises everything.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsub_result_buffer;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_y;
    logic             in_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_y;
    logic             out_ovf;
    logic             flag_clr;
    logic             flag_ovf;
    logic             flag_nan;
    logic             flag_zero;
    logic [CNT_W-1:0] retired;

    fsub_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_y      (in_y),
        .in_ovf    (in_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_ovf   (out_ovf),
        .flag_clr  (flag_clr),
        .flag_ovf  (flag_ovf),
        .flag_nan  (flag_nan),
        .flag_zero (flag_zero),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Checking bookkeeping
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------------
    // Reference model: an in-order queue of accepted entries
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] y;
        logic        ovf;
    } entry_t;

    entry_t           m_q[$];
    logic             m_ovf;
    logic             m_nan;
    logic             m_zero;
    logic [CNT_W-1:0] m_ret;

    initial begin
        m_ovf  = 1'b0;
        m_nan  = 1'b0;
        m_zero = 1'b0;
        m_ret  = '0;
    end

    always @(posedge clk) begin
        bit     acc;
        bit     take;
        entry_t e;
        if (rst) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_nan  = 1'b0;
            m_zero = 1'b0;
            m_ret  = '0;
        end else begin
            acc  = in_valid && (m_q.size() < DEPTH);
            take = out_ready && (m_q.size() > 0);
            if (flag_clr) begin
                m_ovf  = 1'b0;
                m_nan  = 1'b0;
                m_zero = 1'b0;
            end
            if (acc) begin
                if (in_ovf) m_ovf = 1'b1;
                if (in_y[30:23] == 8'd255 && in_y[22:0] != 0) m_nan = 1'b1;
                if (in_y[30:23] == 8'd0 && in_y[22:0] == 0) m_zero = 1'b1;
            end
            if (take) begin
                void'(m_q.pop_front());
                m_ret = m_ret + 1'b1;
            end
            if (acc) begin
                e.y   = in_y;
                e.ovf = in_ovf;
                m_q.push_back(e);
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  in_ready,  (m_q.size() != DEPTH));
            chk("out_valid", out_valid, (m_q.size() != 0));
            chk("out_y",     out_y,     (m_q.size() != 0) ? m_q[0].y : 32'd0);
            chk("out_ovf",   out_ovf,   (m_q.size() != 0) ? m_q[0].ovf : 1'b0);
            chk("flag_ovf",  flag_ovf,  m_ovf);
            chk("flag_nan",  flag_nan,  m_nan);
            chk("flag_zero", flag_zero, m_zero);
            chk("retired",   retired,   m_ret);
            chk("count_bound", (dut.r_count <= DEPTH), 1'b1);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change only just after a falling edge)
    // ------------------------------------------------------------------------
    task automatic drive(input logic v, input logic [31:0] y, input logic o,
                         input logic rdy, input logic clr);
        in_valid  = v;
        in_y      = y;
        in_ovf    = o;
        out_ready = rdy;
        flag_clr  = clr;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 32'd0, 0, 0, 0);
        step();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        drive(0, 32'd0, 0, 0, 0);
        step();
        chk_en = 1'b1;
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_y",     out_y,     0);
        chk("rst_retired",   retired,   0);

        // Single push of 3.0 into an empty buffer
        drive(1, 32'h40400000, 0, 0, 0); step();
        chk("p1_out_valid", out_valid, 1);
        chk("p1_out_y",     out_y,     32'h40400000);
        chk("p1_in_ready",  in_ready,  1);
        chk("p1_flags",     {flag_ovf, flag_nan, flag_zero}, 0);

        // Fill to DEPTH, blocked third push, then drain
        do_reset();
        drive(1, 32'h3F800000, 0, 0, 0); step();
        drive(1, 32'hC0000000, 0, 0, 0); step();
        chk("full_in_ready", in_ready, 0);
        drive(1, 32'h12345678, 0, 0, 0); step();
        chk("blk_in_ready", in_ready, 0);
        chk("blk_head",     out_y,    32'h3F800000);
        drive(0, 32'd0, 0, 1, 0); step();
        chk("pop1_out_y",   out_y,    32'hC0000000);
        chk("pop1_retired", retired,  1);
        step();
        chk("pop2_out_valid", out_valid, 0);
        chk("pop2_out_y",     out_y,     0);
        chk("pop2_retired",   retired,   2);

        // Continuous stream with consumer always ready
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h41000000 + 32'(i), 0, 1, 0); step();
            chk("stream_valid", out_valid, 1);
            chk("stream_y",     out_y,     32'h41000000 + 32'(i));
        end
        drive(0, 32'd0, 0, 1, 0); step();
        chk("stream_empty",   out_valid, 0);
        chk("stream_retired", retired,   8);

        // Sticky flags
        do_reset();
        drive(1, 32'h7F800000, 1, 1, 0); step();
        chk("inf_flags", {flag_ovf, flag_nan, flag_zero}, 3'b100);
        drive(1, 32'h7FC00000, 0, 1, 0); step();
        chk("nan_flags", {flag_ovf, flag_nan, flag_zero}, 3'b110);
        drive(1, 32'h80000000, 0, 1, 0); step();
        chk("zero_flags", {flag_ovf, flag_nan, flag_zero}, 3'b111);
        drive(1, 32'h7FC00000, 0, 1, 1); step();
        chk("clr_set_flags", {flag_ovf, flag_nan, flag_zero}, 3'b010);
        drive(0, 32'd0, 0, 1, 1); step();
        chk("clr_flags", {flag_ovf, flag_nan, flag_zero}, 3'b000);

        // Reset with two entries held, flags set, retired=5, concurrent push/pop
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h3F000000 + 32'(i), 0, 1, 0); step();
        end
        drive(0, 32'd0, 0, 1, 0); step();
        chk("pre_retired", retired, 5);
        drive(1, 32'h7F800000, 1, 0, 0); step();
        drive(1, 32'h80000000, 0, 0, 0); step();
        chk("pre_full",  in_ready, 0);
        chk("pre_flags", {flag_ovf, flag_nan, flag_zero}, 3'b101);
        rst = 1'b1;
        drive(1, 32'h3F800000, 0, 1, 0); step();
        rst = 1'b0;
        drive(0, 32'd0, 0, 0, 0);
        chk("rst2_out_valid", out_valid, 0);
        chk("rst2_out_y",     out_y,     0);
        chk("rst2_in_ready",  in_ready,  1);
        chk("rst2_flags",     {flag_ovf, flag_nan, flag_zero}, 0);
        chk("rst2_retired",   retired,   0);
        step();
        chk("rst2_not_stored", out_valid, 0);

        // Randomized phase, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] y;
            int          sel;
            y   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) y[30:23] = 8'hFF;
            if (sel == 1) y[30:0]  = 31'd0;
            if (sel == 2) y[30:0]  = 31'h7F800000;
            rst = ($urandom_range(0, 99) == 0);
            drive(($urandom_range(0, 9) < 7), y, ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 15) == 0));
            step();
        end
        rst = 1'b0;
        drive(0, 32'd0, 0, 1, 0);
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fsub_result_buffer.md
Name: fsub_result_buffer

Overview:
- Registered output stage that sits directly downstream of the combinational single-precision subtractor.
- Captures the subtractor result word and overflow flag under a valid/ready handshake and holds them in a small FIFO.
- Presents results in order to the consumer (register-file writeback).
- Keeps sticky exception flags (overflow, NaN result, zero result) for the FPU status register.

Parameters:
- DEPTH, 2, number of FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the retired-result counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  subtractor output is valid this cycle.
- in_ready  out  1  buffer can accept an entry this cycle.
- in_y  in  32  subtractor result {sign, exp[7:0], mant[22:0]}.
- in_ovf  in  1  subtractor overflow indication.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer takes head entry.
- out_y  out  32  head result; 0 when out_valid=0.
- out_ovf  out  1  head overflow flag; 0 when out_valid=0.
- flag_clr  in  1  clears all sticky flags.
- flag_ovf  out  1  sticky: an accepted entry had in_ovf=1.
- flag_nan  out  1  sticky: an accepted entry had exp=255 and mant!=0.
- flag_zero  out  1  sticky: an accepted entry had exp=0 and mant=0 (either sign).
- retired  out  CNT_W  count of popped entries; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at an edge):
  - count=0, read/write pointers=0, all flags=0, retired=0.
  - Therefore out_valid=0, out_y=0, out_ovf=0, in_ready=1 the cycle after.
  - Entry storage is not reset.
  - Reset overrides every simultaneous push, pop and flag event.
- Push: in_valid & in_ready at an edge. Writes {in_y, in_ovf} at wptr; wptr increments, wrapping at DEPTH.
- Pop: out_valid & out_ready at an edge. rptr increments, wrapping at DEPTH; retired increments, wrapping from all-ones to 0.
- in_ready = (count != DEPTH). It depends only on registered state and has no combinational path from out_ready. When full, in_ready stays 0 even if a pop occurs in the same cycle.
- out_valid = (count != 0). out_y/out_ovf are driven from the entry at rptr, gated to 0 when empty.
- Latency: an entry pushed into an empty buffer appears on out_valid/out_y in the next cycle. There is no same-cycle bypass.
- Simultaneous push and pop when 0<count<DEPTH: count unchanged, both pointers advance, order preserved.
- Push when empty with out_ready=1: the entry is stored; the pop happens no earlier than the next cycle.
- in_valid with in_ready=0: nothing is stored. The producer holds its inputs; the upstream register stage holds operands while in_ready=0.
- Sticky flags:
  - Evaluated on the pushed data at push time, not at pop.
  - Each flag is set at an edge when its condition holds for a push.
  - flag_clr=1 clears all flags at the edge.
  - If flag_clr and a setting push coincide, set wins for that flag; the others clear.
  - The NaN test uses exp==8'hFF && mant!=0. Infinity (mant=0) does not set flag_nan.
- Count is kept as a clog2(DEPTH)+1 bit register. Underflow and overflow are impossible by construction; the bench asserts this.

Test Plan:
- Reset, then push in_y=32'h40400000 (3.0) with out_ready=0 → next cycle out_valid=1, out_y=32'h40400000, in_ready=1; flags all 0.
- DEPTH=2: push 32'h3F800000 then 32'hC0000000 with out_ready=0 → in_ready=0 after the second push. A third in_valid is not stored. Then pop both with out_ready=1 → outputs are 3F800000 then C0000000, retired=2, out_valid=0, out_y=0.
- Continuous stream of 8 pushes with out_ready=1 every cycle → each result emerges 1 cycle after push in order; count never exceeds 1; retired=8.
- Push 32'h7F800000 with in_ovf=1, then 32'h7FC00000, then 32'h80000000 → flag_ovf=1, flag_nan=1, flag_zero=1. Infinity alone does not set flag_nan.
- flag_clr=1 in the same cycle as a push of 32'h7FC00000 → flag_nan=1, flag_ovf=0, flag_zero=0 after the edge.
- Buffer holding 2 entries, flags set, retired=5, then rst=1 for one cycle concurrent with in_valid and out_ready → out_valid=0, out_y=0, in_ready=1, flags 0, retired=0. The concurrent push is not stored.
